// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: shift-kind encoding, default widths
// and the bit positions of the architectural flags.
package shift_issue_stage_pkg;

    localparam int AMT_W_DEF = 8;
    localparam int RD_W_DEF  = 5;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        KIND_PASS  = 2'd0,
        KIND_SHIFT = 2'd1,
        KIND_EQ32  = 2'd2,
        KIND_OVER  = 2'd3
    } shiftKind_e;

    // Bit shifted in from the top: the sign only for arithmetic right shifts
    function automatic logic fillBit(input logic msb, input logic right, input logic arith);
        return msb & right & arith;
    endfunction

endpackage

// File: rtl/shift_issue_stage_amt_decode.sv
// Classifies a requested shift amount and resolves the results of the amounts
// the 5-bit barrel shifter cannot express (0, 32 and above 32).
module shift_issue_stage_amt_decode
    import shift_issue_stage_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic [31:0]      d_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             right_i,
    input  logic             arith_i,
    output shiftKind_e       kind_o,
    output logic [31:0]      ovrResult_o,
    output logic             ovrCarry_o,
    output logic [4:0]       sa_o
);

    logic fill;

    // PASS and SHIFT keep d as the override value; only EQ32/OVER replace it
    always_comb begin
        fill        = fillBit(d_i[31], right_i, arith_i);
        ovrResult_o = d_i;
        ovrCarry_o  = 1'b0;
        sa_o        = 5'd0;
        if (amt_i == '0) begin
            kind_o = KIND_PASS;
        end else if (amt_i < AMT_W'(32)) begin
            kind_o = KIND_SHIFT;
        end else if (amt_i == AMT_W'(32)) begin
            kind_o = KIND_EQ32;
        end else begin
            kind_o = KIND_OVER;
        end

        case (kind_o)
            KIND_SHIFT: sa_o = amt_i[4:0];
            KIND_EQ32: begin
                if (right_i) begin
                    ovrResult_o = {32{fill}};
                    ovrCarry_o  = d_i[31];
                end else begin
                    ovrResult_o = 32'h0;
                    ovrCarry_o  = d_i[0];
                end
            end
            KIND_OVER: begin
                ovrResult_o = {32{fill}};
                ovrCarry_o  = fill;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage shift execute stage: S1 holds the decoded op and drives the external
// barrel shifter, S2 holds the result for writeback and owns the N/Z/C flags.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF,
    parameter int RD_W  = RD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_d,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_right,
    input  logic             in_arith,
    input  logic             in_setf,
    input  logic [RD_W-1:0]  in_rd,
    output logic [31:0]      sh_d,
    output logic [4:0]       sh_sa,
    output logic             sh_right,
    output logic             sh_arith,
    input  logic [31:0]      sh_result,
    input  logic             sh_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_c,
    output logic [RD_W-1:0]  out_rd,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c
);

    logic             s1Valid_q, s1Valid_d;
    logic [31:0]      s1D_q, s1D_d;
    logic [4:0]       s1Sa_q, s1Sa_d;
    logic             s1Right_q, s1Right_d;
    logic             s1Arith_q, s1Arith_d;
    logic             s1Setf_q, s1Setf_d;
    logic [RD_W-1:0]  s1Rd_q, s1Rd_d;
    shiftKind_e       s1Kind_q, s1Kind_d;
    logic [31:0]      s1OvrResult_q, s1OvrResult_d;
    logic             s1OvrC_q, s1OvrC_d;

    logic             s2Valid_q, s2Valid_d;
    logic [31:0]      s2Result_q, s2Result_d;
    logic             s2C_q, s2C_d;
    logic             s2KeepC_q, s2KeepC_d;
    logic             s2Setf_q, s2Setf_d;
    logic [RD_W-1:0]  s2Rd_q, s2Rd_d;

    logic [2:0]       flags_q, flags_d;

    shiftKind_e       decKind;
    logic [31:0]      decOvrResult;
    logic             decOvrCarry;
    logic [4:0]       decSa;

    logic             accept;
    logic             s1Advance;
    logic             retire;

    shift_issue_stage_amt_decode #(.AMT_W(AMT_W)) uDecode (
        .d_i         (in_d),
        .amt_i       (in_amt),
        .right_i     (in_right),
        .arith_i     (in_arith),
        .kind_o      (decKind),
        .ovrResult_o (decOvrResult),
        .ovrCarry_o  (decOvrCarry),
        .sa_o        (decSa)
    );

    // Handshakes are pure register ANDs/ORs so out_ready reaches in_ready in one level
    assign s1Advance = s1Valid_q & (~s2Valid_q | out_ready);
    assign retire    = s2Valid_q & out_ready;
    assign in_ready  = ~s1Valid_q | ~s2Valid_q | out_ready;
    assign accept    = in_valid & in_ready;

    assign sh_d     = s1D_q;
    assign sh_sa    = s1Sa_q;
    assign sh_right = s1Right_q;
    assign sh_arith = s1Arith_q & s1Right_q;

    assign out_valid  = s2Valid_q;
    assign out_result = s2Result_q;
    assign out_c      = s2KeepC_q ? flags_q[FLAG_C] : s2C_q;
    assign out_rd     = s2Rd_q;
    assign flag_n     = flags_q[FLAG_N];
    assign flag_z     = flags_q[FLAG_Z];
    assign flag_c     = flags_q[FLAG_C];

    always_comb begin
        s1Valid_d     = s1Valid_q;
        s1D_d         = s1D_q;
        s1Sa_d        = s1Sa_q;
        s1Right_d     = s1Right_q;
        s1Arith_d     = s1Arith_q;
        s1Setf_d      = s1Setf_q;
        s1Rd_d        = s1Rd_q;
        s1Kind_d      = s1Kind_q;
        s1OvrResult_d = s1OvrResult_q;
        s1OvrC_d      = s1OvrC_q;
        s2Valid_d     = s2Valid_q;
        s2Result_d    = s2Result_q;
        s2C_d         = s2C_q;
        s2KeepC_d     = s2KeepC_q;
        s2Setf_d      = s2Setf_q;
        s2Rd_d        = s2Rd_q;
        flags_d       = flags_q;

        if (accept) begin
            s1Valid_d     = 1'b1;
            s1D_d         = in_d;
            s1Sa_d        = decSa;
            s1Right_d     = in_right;
            s1Arith_d     = in_arith;
            s1Setf_d      = in_setf;
            s1Rd_d        = in_rd;
            s1Kind_d      = decKind;
            s1OvrResult_d = decOvrResult;
            s1OvrC_d      = decOvrCarry;
        end else if (s1Advance) begin
            s1Valid_d = 1'b0;
        end

        // PASS carry is left open here and filled in from flag_c when it retires
        if (s1Advance) begin
            s2Valid_d  = 1'b1;
            s2Result_d = (s1Kind_q == KIND_SHIFT) ? sh_result : s1OvrResult_q;
            s2C_d      = (s1Kind_q == KIND_SHIFT) ? sh_c : s1OvrC_q;
            s2KeepC_d  = (s1Kind_q == KIND_PASS);
            s2Setf_d   = s1Setf_q;
            s2Rd_d     = s1Rd_q;
        end else if (retire) begin
            s2Valid_d = 1'b0;
        end

        if (retire && s2Setf_q) begin
            flags_d[FLAG_N] = out_result[31];
            flags_d[FLAG_Z] = (out_result == 32'h0);
            flags_d[FLAG_C] = out_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q     <= 1'b0;
            s1D_q         <= 32'h0;
            s1Sa_q        <= 5'd0;
            s1Right_q     <= 1'b0;
            s1Arith_q     <= 1'b0;
            s1Setf_q      <= 1'b0;
            s1Rd_q        <= '0;
            s1Kind_q      <= KIND_PASS;
            s1OvrResult_q <= 32'h0;
            s1OvrC_q      <= 1'b0;
            s2Valid_q     <= 1'b0;
            s2Result_q    <= 32'h0;
            s2C_q         <= 1'b0;
            s2KeepC_q     <= 1'b0;
            s2Setf_q      <= 1'b0;
            s2Rd_q        <= '0;
            flags_q       <= 3'b000;
        end else begin
            s1Valid_q     <= s1Valid_d;
            s1D_q         <= s1D_d;
            s1Sa_q        <= s1Sa_d;
            s1Right_q     <= s1Right_d;
            s1Arith_q     <= s1Arith_d;
            s1Setf_q      <= s1Setf_d;
            s1Rd_q        <= s1Rd_d;
            s1Kind_q      <= s1Kind_d;
            s1OvrResult_q <= s1OvrResult_d;
            s1OvrC_q      <= s1OvrC_d;
            s2Valid_q     <= s2Valid_d;
            s2Result_q    <= s2Result_d;
            s2C_q         <= s2C_d;
            s2KeepC_q     <= s2KeepC_d;
            s2Setf_q      <= s2Setf_d;
            s2Rd_q        <= s2Rd_d;
            flags_q       <= flags_d;
        end
    end

endmodule
